// File: rtl/dot_product_feeder.sv
// dot_product_feeder: serial element-pair loader and result register
// for a combinational dot_product core. Pairs stream in over
// valid/ready, are packed into zero-filled vectors that drive the core,
// and the core's result is captured and offered on a valid/ready output.
module dot_product_feeder #(
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_a,
    input  logic [N-1:0]             in_b,
    input  logic                     in_last,
    output logic [N*N-1:0]           vec_a,
    output logic [N*N-1:0]           vec_b,
    input  logic [2*N-1:0]           dp_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*N-1:0]           out_result,
    output logic                     out_short,
    output logic [$clog2(N+1)-1:0]   elem_count
);

    localparam int CNT_W = $clog2(N + 1);
    // Slot index width; kept at least one bit so N=1 still elaborates.
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [N-1:0][N-1:0] a_q;
    logic [N-1:0][N-1:0] b_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              short_q;
    logic              accept;
    logic              close_vec;
    logic              out_hs;
    logic [IDX_W-1:0]  slot;

    assign accept    = in_valid && in_ready;
    // A vector closes on an explicit last or when the final slot is filled.
    assign close_vec = accept && (in_last || (cnt_q == CNT_W'(N - 1)));
    assign out_hs    = out_valid && out_ready;
    // cnt_q never exceeds N-1 while loading, so the low bits address the slot.
    assign slot      = cnt_q[IDX_W-1:0];

    assign vec_a      = a_q;
    assign vec_b      = b_q;
    assign elem_count = cnt_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    // Next-state logic: LOAD until close, one settle cycle, then hold in OUT.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (close_vec) state_nxt = CALC;
            CALC:    state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Output decode; in_ready is also gated by reset so nothing is
    // advertised while the block is held in reset.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            LOAD:    in_ready  = rst_n;
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    // Vector assembly: write slot on accept, note short close, clear on handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            short_q <= 1'b0;
        end else begin
            if (state == LOAD && accept) begin
                a_q[slot] <= in_a;
                b_q[slot] <= in_b;
                cnt_q     <= cnt_q + CNT_W'(1);
                // cnt+1 < N is the same test as cnt < N-1.
                if (close_vec) short_q <= (cnt_q < CNT_W'(N - 1));
            end
            if (out_hs) begin
                a_q   <= '0;
                b_q   <= '0;
                cnt_q <= '0;
            end
        end
    end

    // Result capture at the end of the settle cycle; held through OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_short  <= 1'b0;
        end else if (state == CALC) begin
            out_result <= dp_result;
            out_short  <= short_q;
        end
    end

endmodule

// File: tb/tb_dot_product_feeder.sv
// Bench for dot_product_feeder: models the attached core combinationally
// and checks results against a pair-list reference.
module tb_dot_product_feeder;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N-1:0]      in_a = '0;
    logic [N-1:0]      in_b = '0;
    logic              in_last = 1'b0;
    logic [N*N-1:0]    vec_a;
    logic [N*N-1:0]    vec_b;
    logic [2*N-1:0]    dp_result;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [2*N-1:0]    out_result;
    logic              out_short;
    logic [CW-1:0]     elem_count;
    logic [2*N-1:0]    core_sum;

    int n_cmp = 0;
    int n_err = 0;

    dot_product_feeder #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .vec_a(vec_a), .vec_b(vec_b),
        .dp_result(dp_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_short(out_short), .elem_count(elem_count)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational dot_product core.
    always_comb begin
        core_sum = '0;
        for (int i = 0; i < N; i++)
            core_sum = core_sum + (2*N)'(vec_a[i*N +: N]) * (2*N)'(vec_b[i*N +: N]);
        dp_result = core_sum;
    end

    // Reference: plain sum of products of the pairs sent, mod 2^(2N).
    function automatic logic [2*N-1:0] ref_dot(input int a[$], input int b[$]);
        int s = 0;
        foreach (a[i]) s += a[i] * b[i];
        return (2*N)'(s);
    endfunction

    // Offer one pair at a negedge once in_ready is seen; returns at the next negedge.
    task automatic push_pair(input int a, input int b, input bit last);
        int w = 0;
        while (!in_ready && w < 200) begin @(negedge clk); w++; end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL push_wait: in_ready=%b after %0d cycles, required 1", in_ready, w);
        end
        in_valid = 1'b1; in_a = N'(a); in_b = N'(b); in_last = last;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Wait for a result, stall a number of cycles checking hold, then handshake.
    task automatic collect(input logic [2*N-1:0] er, input bit es, input int stall, input string nm);
        int w = 0;
        out_ready = 1'b0;
        while (!out_valid && w < 200) begin @(negedge clk); w++; end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL %s_valid: out_valid=%b, required 1", nm, out_valid);
        end
        for (int k = 0; k < stall; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_result !== er || in_ready !== 1'b0) begin
                n_err++; $display("FAIL %s_hold: valid=%b result=%0d ready=%b, required 1/%0d/0",
                                  nm, out_valid, out_result, in_ready, er);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (out_result !== er || out_short !== es) begin
            n_err++; $display("FAIL %s_result: result=%0d short=%b, required %0d/%b",
                              nm, out_result, out_short, er, es);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || elem_count !== '0) begin
            n_err++; $display("FAIL %s_release: out_valid=%b elem_count=%0d, required 0/0",
                              nm, out_valid, elem_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || elem_count !== '0 || vec_a !== '0 ||
            vec_b !== '0 || out_result !== '0 || out_short !== 1'b0) begin
            n_err++; $display("FAIL reset_state: ready=%b valid=%b cnt=%0d va=%h res=%0d short=%b, required all 0",
                              in_ready, out_valid, elem_count, vec_a, out_result, out_short);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int i = 0; i < N; i++) push_pair(i + 1, N - i, i == N - 1);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || elem_count !== CW'(N)) begin
            n_err++; $display("FAIL basic_calc: valid=%b ready=%b cnt=%0d, required 0/0/%0d",
                              out_valid, in_ready, elem_count, N);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_result !== 16'd120 || out_short !== 1'b0) begin
            n_err++; $display("FAIL basic_latency: valid=%b result=%0d short=%b, required 1/120/0",
                              out_valid, out_result, out_short);
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || elem_count !== '0 || vec_a !== '0) begin
            n_err++; $display("FAIL basic_after_hs: valid=%b ready=%b cnt=%0d va=%h, required 0/1/0/0",
                              out_valid, in_ready, elem_count, vec_a);
        end
    endtask

    task automatic test_short();
        logic [3*N-1:0] exp_lo;
        exp_lo = {8'd3, 8'd2, 8'd1};
        push_pair(1, 4, 0); push_pair(2, 5, 0); push_pair(3, 6, 1);
        n_cmp++;
        if (elem_count !== CW'(3) || vec_a[N*N-1:3*N] !== '0 || vec_a[3*N-1:0] !== exp_lo) begin
            n_err++; $display("FAIL short_vec: cnt=%0d va=%h, required 3/%h zero-filled",
                              elem_count, vec_a, exp_lo);
        end
        collect(16'd32, 1'b1, 0, "short");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < N; i++) push_pair(255, 255, i == N - 1);
        collect(16'd61448, 1'b0, 2, "wrap");
    endtask

    task automatic test_backpressure();
        logic [N*N-1:0] exp_va;
        int qa[$], qb[$];
        for (int i = 0; i < N; i++) begin
            exp_va[i*N +: N] = N'(i + 1);
            push_pair(i + 1, N - i, i == N - 1);
        end
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_result !== 16'd120 || in_ready !== 1'b0 ||
                vec_a !== exp_va || elem_count !== CW'(N)) begin
                n_err++; $display("FAIL bp_hold%0d: valid=%b result=%0d ready=%b cnt=%0d, required 1/120/0/%0d",
                                  k, out_valid, out_result, in_ready, elem_count, N);
            end
            in_valid = k[0]; in_a = N'($urandom); in_b = N'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++;
        if (vec_a !== exp_va || out_result !== 16'd120) begin
            n_err++; $display("FAIL bp_nolatch: va=%h result=%0d, required %h/120", vec_a, out_result, exp_va);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            qa.push_back(int'($urandom_range(0, 255))); qb.push_back(int'($urandom_range(0, 255)));
            push_pair(qa[i], qb[i], i == 4);
        end
        collect(ref_dot(qa, qb), 1'b1, 1, "bp_next");
    endtask

    task automatic test_reset_mid();
        int qa[$], qb[$];
        bit seen = 0;
        for (int i = 0; i < 4; i++) push_pair(i + 7, i + 3, 0);
        n_cmp++;
        if (elem_count !== CW'(4)) begin
            n_err++; $display("FAIL rstmid_pre: cnt=%0d, required 4", elem_count);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (elem_count !== '0 || vec_a !== '0 || vec_b !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL rstmid_clear: cnt=%0d va=%h vb=%h valid=%b ready=%b, required all 0",
                              elem_count, vec_a, vec_b, out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) seen = 1;
            @(negedge clk);
        end
        n_cmp++;
        if (seen) begin
            n_err++; $display("FAIL rstmid_noout: out_valid seen=1, required 0");
        end
        for (int i = 0; i < N; i++) begin
            qa.push_back(int'($urandom_range(0, 255))); qb.push_back(int'($urandom_range(0, 255)));
            push_pair(qa[i], qb[i], i == N - 1);
        end
        collect(ref_dot(qa, qb), 1'b0, 0, "rstmid_fresh");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < N; i++) push_pair(i + 1, N - i, 0);
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd3; in_last = 1'b1; out_ready = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b0 || elem_count !== CW'(N)) begin
            n_err++; $display("FAIL ovf_close: ready=%b cnt=%0d, required 0/%0d", in_ready, elem_count, N);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_result !== 16'd120 || out_short !== 1'b0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL ovf_result: valid=%b result=%0d short=%b ready=%b, required 1/120/0/0",
                              out_valid, out_result, out_short, in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || elem_count !== '0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL ovf_hs: valid=%b cnt=%0d ready=%b, required 0/0/1",
                              out_valid, elem_count, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (elem_count !== CW'(1) || vec_a[N-1:0] !== 8'd9 || vec_b[N-1:0] !== 8'd3) begin
            n_err++; $display("FAIL ovf_slot0: cnt=%0d a0=%0d b0=%0d, required 1/9/3",
                              elem_count, vec_a[N-1:0], vec_b[N-1:0]);
        end
        collect(16'd27, 1'b1, 0, "ovf_next");
    endtask

    task automatic test_random();
        for (int v = 0; v < 25; v++) begin
            int qa[$], qb[$];
            int len;
            bit full_last;
            len = int'($urandom_range(1, N));
            full_last = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                qa.push_back(int'($urandom_range(0, 255))); qb.push_back(int'($urandom_range(0, 255)));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push_pair(qa[i], qb[i], (i == len - 1) && (len < N || full_last));
            end
            collect(ref_dot(qa, qb), len < N, int'($urandom_range(0, 3)), "rand");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_overflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
